// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   NOP_INSTR   : word presented on if_inst while the prefetch buffer is empty
//   PC_STEP     : sequential fetch increment in bytes
//   fetch_entry : one prefetch buffer entry (instruction plus the PC that produced it)
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail (must not be asserted while full)
//   pop_i         : drop the head entry (ignored while empty)
//   flush_i       : empty the FIFO; overrides push and pop in the same cycle
//   valid_o       : head_o holds a valid entry
//   head_o        : head entry
//   count_o       : number of stored entries (0..DEPTH)
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fetch_entry               push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output fetch_entry               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

  fetch_entry            mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push_eff, pop_eff;

  assign push_eff = push_i & ~flush_i;
  assign pop_eff  = pop_i & ~flush_i & (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_eff);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_eff);
      count_d  = count_q + CntW'(push_eff) - CntW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The issue throttle upstream must keep a response from landing on a full buffer.
  no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && (count_q == CountFull)));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word addresses to a single-cycle
// instruction memory, buffers returned words and hands them to decode.
//   clk, rst         : clock, asynchronous active-low reset
//   imem_addr        : fetch address (combinational, redirect target bypasses the PC)
//   imem_inst        : instruction for the address issued last cycle
//   imem_addr_echo   : address that produced imem_inst
//   if_valid/ready   : decode handshake; if_inst/if_pc describe the buffer head
//   redirect_valid   : control-flow change; flushes buffered words and refetches
//   redirect_pc      : redirect target, low two bits ignored
module inst_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic [31:0] imem_addr_echo,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic            fifo_valid;
  fetch_entry      fifo_head;
  fetch_entry      push_data;
  logic [CntW-1:0] fifo_count;
  logic            pop;
  logic            push;
  logic            issue;
  logic [OccW-1:0] occupancy;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;

  assign pop = fifo_valid & if_ready;

  // Buffered words plus the one in flight, less the one leaving this cycle, must
  // leave room for the word we are about to request. pop implies count >= 1.
  assign occupancy = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
  assign issue     = redirect_valid | (occupancy < OccW'(FIFO_DEPTH));

  // A response arriving during a redirect belongs to the old path and is dropped.
  assign push      = inflight_q & ~redirect_valid;
  assign push_data = '{inst: imem_inst, pc: imem_addr_echo};

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    if (issue) begin
      pc_d = imem_addr + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign if_valid = fifo_valid;
  assign if_inst  = fifo_valid ? fifo_head.inst : NOP_INSTR;
  assign if_pc    = fifo_valid ? fifo_head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: a registered instruction memory responder plus a
// transaction-level model (queue of expected PCs) checked every cycle.
module tb_inst_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          Depth   = 2;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst = '0;
  logic [31:0] imem_addr_echo = '0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] mq [$];
  logic [31:0] m_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .imem_addr_echo (imem_addr_echo),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Single-cycle memory: address sampled at posedge, data valid the next cycle.
  always @(posedge clk) begin
    imem_inst      <= memf(imem_addr);
    imem_addr_echo <= imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc          = ResetPc;
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] addr;
    logic        pop;
    logic        issue;
    int          occ;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #4;
    addr = rv ? {rpc[31:2], 2'b00} : m_pc;
    check("imem_addr", imem_addr, addr);
    check("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("if_pc", if_pc, mq[0]);
      check("if_inst", if_inst, memf(mq[0]));
    end else begin
      check("if_pc_empty", if_pc, 32'h0);
      check("if_inst_empty", if_inst, Nop);
    end
    pop   = (mq.size() != 0) && rdy;
    occ   = mq.size() + int'(m_inflight) - int'(pop);
    issue = rv || (occ < Depth);
    if (rv) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_inflight_pc);
    end
    m_inflight    = issue;
    m_inflight_pc = addr;
    if (issue) m_pc = addr + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_if_valid", {31'b0, if_valid}, 32'h0);
    check("reset_if_inst", if_inst, Nop);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_imem_addr", imem_addr, ResetPc);
    rst = 1'b1;

    // Straight-line fetch from reset.
    repeat (5) step(1'b1, 1'b0, '0);
    // Stall then drain.
    repeat (5) step(1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, '0);
    // Redirect with words queued.
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_002C);
    repeat (4) step(1'b1, 1'b0, '0);
    // Unaligned redirect target.
    step(1'b1, 1'b1, 32'h0000_0027);
    repeat (3) step(1'b1, 1'b0, '0);
    // Redirect together with a pop from a full buffer.
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_0100);
    repeat (3) step(1'b1, 1'b0, '0);
    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (5) step(1'b1, 1'b0, '0);

    // Asynchronous reset with the buffer full.
    repeat (3) step(1'b0, 1'b0, '0);
    rst = 1'b0;
    #2;
    check("midrst_if_valid", {31'b0, if_valid}, 32'h0);
    check("midrst_if_inst", if_inst, Nop);
    check("midrst_imem_addr", imem_addr, ResetPc);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step(1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(rdy, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
